// File: rtl/lut_case_engine.sv
// lut_case_engine
// Programmable select decoder: an SEL_W-bit select vector indexes a
// 2^SEL_W-entry table of OUT_W-bit words. The table is written at run time,
// and a clear request zeroes it with one entry per cycle.
//
// Ports:
//   Clock, Resetn           rising-edge clock, async active-low reset
//   in_valid/in_sel/in_ready  select handshake (accept = in_valid & in_ready)
//   out_valid/out_f         registered result, valid strobes for one cycle
//   cfg_wr/cfg_addr/cfg_data  single-entry table write (IDLE only)
//   cfg_clear/cfg_busy      start table clear sweep / sweep in progress
//   out_par                 (LUT_PARITY_EN only) XOR-reduction of loaded entry
//
// Optional feature macro: LUT_PARITY_EN
module lut_case_engine #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_f,
  input  logic             cfg_wr,
  input  logic [SEL_W-1:0] cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             cfg_clear,
  output logic             cfg_busy
`ifdef LUT_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int DEPTH = 1 << SEL_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][OUT_W-1:0]   tbl_q, tbl_d;
  logic [SEL_W-1:0]              cnt_q, cnt_d;
  logic [OUT_W-1:0]              out_f_q, out_f_d;
  logic                          out_valid_q, out_valid_d;
  logic                          accept;
`ifdef LUT_PARITY_EN
  logic                          par_q, par_d;
`endif

  assign in_ready  = (state_q == IDLE);
  assign cfg_busy  = (state_q == CLEAR);
  assign out_f     = out_f_q;
  assign out_valid = out_valid_q;
`ifdef LUT_PARITY_EN
  assign out_par   = par_q;
`endif

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    cnt_d       = cnt_q;
    out_f_d     = out_f_q;
    out_valid_d = 1'b0;
`ifdef LUT_PARITY_EN
    par_d       = par_q;
`endif
    accept      = in_valid && (state_q == IDLE);

    // Lookup reads tbl_q, so a same-cycle write to the same entry is seen
    // only by the next accept.
    if (accept) begin
      out_f_d     = tbl_q[in_sel];
      out_valid_d = 1'b1;
`ifdef LUT_PARITY_EN
      par_d       = ^tbl_q[in_sel];
`endif
    end

    case (state_q)
      IDLE: begin
        // Clear has priority; a coincident write is dropped.
        if (cfg_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cfg_wr) begin
          tbl_d[cfg_addr] = cfg_data;
        end
      end
      CLEAR: begin
        tbl_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;  // wraps to 0 after the last entry
        if (cnt_q == {SEL_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      cnt_q       <= '0;
      out_f_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef LUT_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      cnt_q       <= cnt_d;
      out_f_q     <= out_f_d;
      out_valid_q <= out_valid_d;
`ifdef LUT_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_lut_case_engine.sv
module tb_lut_case_engine;
  localparam int SEL_W = 3;
  localparam int OUT_W = 2;
  localparam int DEPTH = 8;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             in_valid;
  logic [SEL_W-1:0] in_sel;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_f;
  logic             cfg_wr;
  logic [SEL_W-1:0] cfg_addr;
  logic [OUT_W-1:0] cfg_data;
  logic             cfg_clear;
  logic             cfg_busy;
`ifdef LUT_PARITY_EN
  logic             out_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lut_case_engine #(.SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_f(out_f),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_clear(cfg_clear), .cfg_busy(cfg_busy)
`ifdef LUT_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents, remaining clear cycles, last result.
  logic [OUT_W-1:0] m_tbl [DEPTH];
  int               m_clr_left;
  logic [OUT_W-1:0] m_f;
  logic             m_v;
  logic             m_par;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] <= '0;
      m_clr_left <= 0;
      m_f        <= '0;
      m_v        <= 1'b0;
      m_par      <= 1'b0;
    end else if (m_clr_left == 0) begin
      m_v <= in_valid;
      if (in_valid) begin
        m_f   <= m_tbl[in_sel];
        m_par <= ^m_tbl[in_sel];
      end
      if (cfg_clear)   m_clr_left <= DEPTH;
      else if (cfg_wr) m_tbl[cfg_addr] <= cfg_data;
    end else begin
      m_v <= 1'b0;
      m_tbl[DEPTH - m_clr_left] <= '0;
      m_clr_left <= m_clr_left - 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clock) begin
    chk("in_ready",  int'(in_ready),  int'(m_clr_left == 0));
    chk("cfg_busy",  int'(cfg_busy),  int'(m_clr_left != 0));
    chk("out_valid", int'(out_valid), int'(m_v));
    chk("out_f",     int'(out_f),     int'(m_f));
`ifdef LUT_PARITY_EN
    chk("out_par",   int'(out_par),   int'(m_par));
`endif
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; cfg_wr = 1'b0; cfg_clear = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_wr = 1'b1; cfg_addr = SEL_W'(a); cfg_data = OUT_W'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic acc(input int s);
    in_valid = 1'b1; in_sel = SEL_W'(s);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; in_sel = '0; cfg_addr = '0; cfg_data = '0;
    idle_in();
    #1;
    chk("rst_out_f", int'(out_f), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(cfg_busy), 0);
    repeat (2) @(posedge Clock);
    #2 Resetn = 1'b1;

    // 1: empty table reads zero, strobe lasts one cycle
    acc(5);
    chk("t1_f", int'(out_f), 0);
    chk("t1_v", int'(out_valid), 1);
    tick();
    chk("t1_v_drop", int'(out_valid), 0);
    chk("t1_hold", int'(out_f), 0);

    // 2: programmed entries, back-to-back accepts
    wr(1, 1); wr(2, 2); wr(6, 3);
    in_valid = 1'b1;
    in_sel = 3'd1; tick(); chk("t2_f1", int'(out_f), 1); chk("t2_v1", int'(out_valid), 1);
    in_sel = 3'd2; tick(); chk("t2_f2", int'(out_f), 2); chk("t2_v2", int'(out_valid), 1);
    in_sel = 3'd6; tick(); chk("t2_f6", int'(out_f), 3); chk("t2_v6", int'(out_valid), 1);
    in_valid = 1'b0;

    // 3: read-before-write on same entry
    in_valid = 1'b1; in_sel = 3'd2;
    cfg_wr = 1'b1; cfg_addr = 3'd2; cfg_data = 2'b01;
    tick();
    idle_in();
    chk("t3_old", int'(out_f), 2);
    acc(2);
    chk("t3_new", int'(out_f), 1);

    // 4: clear sweep of 8 cycles, write during sweep dropped
    cfg_clear = 1'b1; tick(); cfg_clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_busy", int'(cfg_busy), 1);
      chk("t4_ready", int'(in_ready), 0);
      if (i == 2) begin cfg_wr = 1'b1; cfg_addr = 3'd6; cfg_data = 2'b11; end
      else cfg_wr = 1'b0;
      tick();
    end
    cfg_wr = 1'b0;
    chk("t4_done", int'(cfg_busy), 0);
    acc(6);
    chk("t4_f6", int'(out_f), 0);

    // 5: reset in the middle of a sweep
    wr(3, 3); acc(3);
    chk("t5_pre", int'(out_f), 3);
    cfg_clear = 1'b1; tick(); cfg_clear = 1'b0;
    tick(); tick(); tick();
    Resetn = 1'b0;
    #1;
    chk("t5_f", int'(out_f), 0);
    chk("t5_v", int'(out_valid), 0);
    chk("t5_busy", int'(cfg_busy), 0);
    chk("t5_ready", int'(in_ready), 1);
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      acc(i);
      chk("t5_zero", int'(out_f), 0);
    end

`ifdef LUT_PARITY_EN
    // 6: parity of loaded entry
    wr(5, 1); acc(5);
    chk("t6_par1", int'(out_par), 1);
    wr(5, 3); acc(5);
    chk("t6_par0", int'(out_par), 0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_sel    = SEL_W'($urandom);
      cfg_wr    = ($urandom_range(0, 99) < 40);
      cfg_addr  = SEL_W'($urandom);
      cfg_data  = OUT_W'($urandom);
      cfg_clear = ($urandom_range(0, 99) < 4);
      tick();
    end
    idle_in();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
